// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO family.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    // Address width that stays at least 1 bit for a single-entry FIFO.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: wraps by explicit compare so any DEPTH works.
module fifo_wrap_ptr #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of arbitrary depth with standard or FWFT read, occupancy
// flags, sticky overflow/underflow and a synchronous flush.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int DW        = 8,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    localparam int AW       = safe_clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o,
    output logic          almost_empty_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    // AF_THRESH may be 0 only for DEPTH==1, where the derived default lands.
    if (DEPTH < 1 || AF_THRESH > DEPTH || AF_THRESH < ((DEPTH == 1) ? 0 : 1)) begin : g_bad_af
        $error("sync_fifo_flex: AF_THRESH out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flex: AE_THRESH out of range");
    end

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          push_acc, pop_acc;

    assign full_o         = (count_q == CW'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= CW'(AF_THRESH));
    assign almost_empty_o = (count_q <= CW'(AE_THRESH));
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    // A flush swallows same-cycle requests, so neither side is accepted.
    assign pop_acc  = pop_i & ~empty_o & ~clr_i;
    assign push_acc = push_i & (~full_o | pop_acc) & ~clr_i;

    fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (push_acc),
        .ptr_o  (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (pop_acc),
        .ptr_o  (rd_ptr)
    );

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_i) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_acc && !pop_acc) begin
                count_d = count_q + 1'b1;
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - 1'b1;
            end
            if (push_i && full_o && !pop_acc) overflow_d = 1'b1;
            if (pop_i && empty_o) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage has no reset; flags and pointers guard every read, and leaving it out keeps it in plain RAM cells.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem[wr_ptr] <= data_i;
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign data_o = empty_o ? '0 : mem[rd_ptr];
    end else begin : g_std
        logic [DW-1:0] data_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q <= '0;
            end else if (clr_i) begin
                data_q <= '0;
            end else if (pop_acc) begin
                data_q <= mem[rd_ptr];
            end
        end

        assign data_o = data_q;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Runs a standard and an FWFT instance side by side on the same stimulus
// against a queue-based model of the FIFO rules.
module tb_sync_fifo_flex;

    localparam int DEPTH = 5;
    localparam int DW    = 8;
    localparam int CW    = 3;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr, push, pop;
    logic [DW-1:0] din;

    logic [DW-1:0] data_s, data_f;
    logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
    logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [CW-1:0] count_s, count_f;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] std_data;
    bit            m_ovf, m_unf;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DW(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .push_i(push), .data_i(din), .pop_i(pop),
        .data_o(data_s), .full_o(full_s), .empty_o(empty_s), .almost_full_o(af_s),
        .almost_empty_o(ae_s), .count_o(count_s), .overflow_o(ovf_s), .underflow_o(unf_s)
    );

    sync_fifo_flex #(.DW(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .push_i(push), .data_i(din), .pop_i(pop),
        .data_o(data_f), .full_o(full_f), .empty_o(empty_f), .almost_full_o(af_f),
        .almost_empty_o(ae_f), .count_o(count_f), .overflow_o(ovf_f), .underflow_o(unf_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        std_data = '0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    // Applies the FIFO rules to the inputs seen at the edge.
    task automatic model_edge();
        int  sz;
        bit  pa, wa;
        sz = q.size();
        if (clr) begin
            model_reset();
        end else begin
            pa = pop && (sz > 0);
            wa = push && ((sz < DEPTH) || pa);
            if (push && (sz == DEPTH) && !pa) m_ovf = 1'b1;
            if (pop && (sz == 0)) m_unf = 1'b1;
            if (pa) std_data = q.pop_front();
            if (wa) q.push_back(din);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        check("std_count", 32'(count_s), 32'(sz));
        check("std_full",  32'(full_s),  32'(sz == DEPTH));
        check("std_empty", 32'(empty_s), 32'(sz == 0));
        check("std_afull", 32'(af_s),    32'(sz >= AF));
        check("std_aempty",32'(ae_s),    32'(sz <= AE));
        check("std_ovf",   32'(ovf_s),   32'(m_ovf));
        check("std_unf",   32'(unf_s),   32'(m_unf));
        check("std_data",  32'(data_s),  32'(std_data));
        check("fw_count",  32'(count_f), 32'(sz));
        check("fw_full",   32'(full_f),  32'(sz == DEPTH));
        check("fw_empty",  32'(empty_f), 32'(sz == 0));
        check("fw_afull",  32'(af_f),    32'(sz >= AF));
        check("fw_aempty", 32'(ae_f),    32'(sz <= AE));
        check("fw_ovf",    32'(ovf_f),   32'(m_ovf));
        check("fw_unf",    32'(unf_f),   32'(m_unf));
        check("fw_data",   32'(data_f),  32'((sz > 0) ? q[0] : 8'h00));
    endtask

    task automatic cycle(input bit c, input bit pu, input bit po, input logic [DW-1:0] d);
        @(negedge clk);
        clr  = c;
        push = pu;
        pop  = po;
        din  = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        din   = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill, drain, and refill so both pointers wrap.
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'h11 + 8'(i));
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'h21 + 8'(i));
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);

        // Single word fall-through, then idle with no pop.
        cycle(0, 1, 0, 8'hA5);
        cycle(0, 0, 0, 8'h00);
        cycle(0, 0, 1, 8'h00);

        // Full with simultaneous push and pop, then drain to see 0x77 last.
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'h31 + 8'(i));
        cycle(0, 1, 1, 8'h77);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);

        // Sticky errors and flush.
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'h41 + 8'(i));
        cycle(0, 1, 0, 8'hEE);
        cycle(0, 0, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 0, 8'h00);
        cycle(1, 1, 1, 8'hCC);
        cycle(0, 0, 0, 8'h00);

        // Asynchronous reset between edges with three words held.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h51 + 8'(i));
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 1, 1, 8'h99);
        cycle(0, 0, 1, 8'h00);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0 ? 1'b0 : ($urandom_range(0, 1) == 1),
                  8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
